// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: one outstanding ibus request at a time, with
// returned instructions buffered in a DEPTH-entry prefetch FIFO for decode.
package fetch_pkg;
  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    inst_t data;
  } ibus_resp_t;
endpackage

module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter int    PC_STEP  = 4,
  parameter addr_t RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  ibus_resp_t             iresp,
  output ibus_req_t              ireq,
  input  logic                   redirect,
  input  addr_t                  redirect_pc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output inst_t                  out_inst,
  output addr_t                  out_pc,
  output logic                   awaiting,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, STALE} state_t;

  state_t          state_reg, state_next;
  addr_t           fetch_pc_reg;
  addr_t           req_addr_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  inst_t           inst_mem [DEPTH];
  addr_t           pc_mem   [DEPTH];

  logic            complete;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW-1:0]   count_after_pop;

  assign complete        = iresp.addr_ok & iresp.data_ok;
  assign pop             = out_valid & out_ready & ~redirect;
  assign push            = (state_reg == BUSY) & complete & ~redirect;
  assign count_after_pop = count_reg - CW'(pop);
  // Issuing only with a free slot reserves room for the eventual push.
  assign issue           = (state_reg == IDLE) & ~redirect & (count_after_pop < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (issue) state_next = BUSY;
      end
      BUSY: begin
        if (complete)      state_next = IDLE;
        else if (redirect) state_next = STALE;
      end
      STALE: begin
        if (complete) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ireq.valid = (state_reg != IDLE);
    ireq.addr  = req_addr_reg;
    awaiting   = (state_reg != IDLE);
    out_valid  = (count_reg != '0);
    out_inst   = inst_mem[rd_ptr_reg];
    out_pc     = pc_mem[rd_ptr_reg];
    count      = count_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else begin
      if (issue) req_addr_reg <= fetch_pc_reg;

      if (redirect)  fetch_pc_reg <= redirect_pc;
      else if (push) fetch_pc_reg <= fetch_pc_reg + addr_t'(PC_STEP);

      if (push) begin
        inst_mem[wr_ptr_reg] <= iresp.data;
        pc_mem[wr_ptr_reg]   <= req_addr_reg;
      end

      // A redirect flushes the queue and wins over any push or pop.
      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a cycle table for streaming,
// backpressure and idle redirect, then sequences for the multi-cycle corners.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int    DEPTH = 4;
  localparam addr_t R     = 64'h0000_0000_8000_0000;
  localparam addr_t X     = 64'h0000_0000_9000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  ibus_resp_t iresp;
  ibus_req_t  ireq;
  logic       redirect = 1'b0;
  addr_t      redirect_pc = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  inst_t      out_inst;
  addr_t      out_pc;
  logic       awaiting;
  logic [$clog2(DEPTH):0] count;

  logic ack = 1'b0;
  logic auto_ack = 1'b0;
  int   total = 0;
  int   bad = 0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(R)) dut (
    .clk(clk), .rst(rst), .iresp(iresp), .ireq(ireq),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_ready(out_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .awaiting(awaiting), .count(count)
  );

  always #5 clk = ~clk;

  function automatic inst_t dat(input addr_t a);
    return a[31:0] ^ 32'hA5A5_A5A5;
  endfunction

  always_comb begin
    iresp.addr_ok = auto_ack ? ireq.valid : ack;
    iresp.data_ok = auto_ack ? ireq.valid : ack;
    iresp.data    = dat(ireq.addr);
  end

  typedef struct {
    logic  rdr;
    addr_t rpc;
    logic  rdy;
    logic  ack;
    logic  ev;
    addr_t ea;
    logic  eov;
    addr_t epc;
    int    ecnt;
  } vec_t;

  vec_t tbl[23];
  int   nrows = 0;

  task automatic add(input logic rdr, input addr_t rpc, input logic rdy, input logic a,
                     input logic ev, input addr_t ea, input logic eov, input addr_t epc,
                     input int ecnt);
    tbl[nrows] = '{rdr, rpc, rdy, a, ev, ea, eov, epc, ecnt};
    nrows++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Ends on a falling edge with reset released and all inputs idle.
  task automatic reset_dut();
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    ack = 1'b0; auto_ack = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //  rdr rpc  rdy ack  ev  ea       eov epc      cnt
    add(0, '0, 1, 0,  0, R,       0, '0,      0);
    add(0, '0, 1, 1,  1, R,       0, '0,      0);
    add(0, '0, 1, 0,  0, R,       1, R,       1);
    add(0, '0, 1, 1,  1, R + 4,   0, '0,      0);
    add(0, '0, 1, 0,  0, R + 4,   1, R + 4,   1);
    add(0, '0, 1, 1,  1, R + 8,   0, '0,      0);
    add(0, '0, 1, 0,  0, R + 8,   1, R + 8,   1);
    add(0, '0, 1, 1,  1, R + 12,  0, '0,      0);
    add(0, '0, 0, 0,  0, R + 12,  1, R + 12,  1);
    add(0, '0, 0, 1,  1, R + 16,  1, R + 12,  1);
    add(0, '0, 0, 0,  0, R + 16,  1, R + 12,  2);
    add(0, '0, 0, 1,  1, R + 20,  1, R + 12,  2);
    add(0, '0, 0, 0,  0, R + 20,  1, R + 12,  3);
    add(0, '0, 0, 1,  1, R + 24,  1, R + 12,  3);
    add(0, '0, 0, 1,  0, R + 24,  1, R + 12,  4);
    add(0, '0, 1, 0,  0, R + 24,  1, R + 12,  4);
    add(0, '0, 0, 1,  1, R + 28,  1, R + 16,  3);
    add(0, '0, 1, 0,  0, R + 28,  1, R + 16,  4);
    add(0, '0, 1, 1,  1, R + 32,  1, R + 20,  3);
    add(1, X,  1, 0,  0, R + 32,  1, R + 24,  3);
    add(0, '0, 1, 0,  0, R + 32,  0, '0,      0);
    add(0, '0, 1, 1,  1, X,       0, '0,      0);
    add(0, '0, 0, 0,  0, X,       1, X,       1);

    reset_dut();
    for (int i = 0; i < nrows; i++) begin
      chk($sformatf("row%0d valid", i), 64'(ireq.valid), 64'(tbl[i].ev));
      chk($sformatf("row%0d awaiting", i), 64'(awaiting), 64'(tbl[i].ev));
      chk($sformatf("row%0d addr", i), ireq.addr, tbl[i].ea);
      chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
      chk($sformatf("row%0d count", i), 64'(count), 64'(tbl[i].ecnt));
      if (tbl[i].eov) begin
        chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("row%0d out_inst", i), 64'(out_inst), 64'(dat(tbl[i].epc)));
      end
      $display("row %0d: valid=%0b addr=%h out_valid=%0b out_pc=%h count=%0d",
               i, ireq.valid, ireq.addr, out_valid, out_pc, count);
      redirect = tbl[i].rdr; redirect_pc = tbl[i].rpc;
      out_ready = tbl[i].rdy; ack = tbl[i].ack;
      step();
    end
    redirect = 1'b0; ack = 1'b0;

    // Redirect while BUSY: response three cycles later is dropped.
    reset_dut();
    chk("reset out_inst", 64'(out_inst), 64'h0);
    chk("reset out_pc", out_pc, R);
    redirect = 1'b1; redirect_pc = 64'h8000_0008; step();
    redirect = 1'b0; step();
    chk("stale issue addr", ireq.addr, 64'h8000_0008);
    redirect = 1'b1; redirect_pc = 64'h8000_0100; step();
    redirect = 1'b0;
    chk("stale awaiting", 64'(awaiting), 64'h1);
    chk("stale valid held", 64'(ireq.valid), 64'h1);
    step(); step();
    chk("stale addr held", ireq.addr, 64'h8000_0008);
    ack = 1'b1; step();
    ack = 1'b0;
    chk("stale drop valid", 64'(ireq.valid), 64'h0);
    chk("stale drop count", 64'(count), 64'h0);
    chk("stale drop out_valid", 64'(out_valid), 64'h0);
    step();
    chk("stale next addr", ireq.addr, 64'h8000_0100);
    chk("stale next valid", 64'(ireq.valid), 64'h1);
    $display("seq redirect-busy: next addr=%h", ireq.addr);

    // Redirect colliding with completion and pop.
    reset_dut();
    step(); ack = 1'b1; step(); ack = 1'b0; step(); ack = 1'b1; step(); ack = 1'b0; step();
    chk("collide pre count", 64'(count), 64'h2);
    chk("collide pre addr", ireq.addr, R + 8);
    redirect = 1'b1; redirect_pc = 64'hA000_0000; ack = 1'b1; out_ready = 1'b1; step();
    redirect = 1'b0; ack = 1'b0; out_ready = 1'b0;
    chk("collide count", 64'(count), 64'h0);
    chk("collide out_valid", 64'(out_valid), 64'h0);
    chk("collide idle", 64'(ireq.valid), 64'h0);
    step();
    chk("collide next addr", ireq.addr, 64'hA000_0000);
    $display("seq collide: count=%0d next addr=%h", count, ireq.addr);

    // Asynchronous reset during a stalled request.
    reset_dut();
    step(); ack = 1'b1; step(); ack = 1'b0; step();
    chk("areset pre valid", 64'(ireq.valid), 64'h1);
    chk("areset pre count", 64'(count), 64'h1);
    #3 rst = 1'b0;
    #1;
    chk("areset valid", 64'(ireq.valid), 64'h0);
    chk("areset count", 64'(count), 64'h0);
    chk("areset awaiting", 64'(awaiting), 64'h0);
    step(); step();
    ack = 1'b1; rst = 1'b1; step();
    chk("areset first addr", ireq.addr, R);
    chk("areset ignored resp", 64'(count), 64'h0);
    step();
    ack = 1'b0;
    chk("areset first push", out_pc, R);
    $display("seq async-reset: first addr=%h", R);

    // Address wrap and FIFO pointer wrap over 3*DEPTH pops.
    reset_dut();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; step();
    redirect = 1'b0; auto_ack = 1'b1;
    begin
      addr_t exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      int    pops = 0;
      for (int cyc = 0; cyc < 400 && pops < 3 * DEPTH; cyc++) begin
        out_ready = (cyc % 3) != 2;
        chk("wrap count bound", 64'(count <= DEPTH), 64'h1);
        if (out_valid && out_ready) begin
          chk($sformatf("wrap pc%0d", pops), out_pc, exp_pc);
          chk($sformatf("wrap inst%0d", pops), 64'(out_inst), 64'(dat(exp_pc)));
          $display("wrap pop %0d: pc=%h inst=%h", pops, out_pc, out_inst);
          exp_pc = exp_pc + 64'd4;
          pops++;
        end
        step();
      end
      chk("wrap pops done", 64'(pops), 64'(3 * DEPTH));
    end
    auto_ack = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
